// File: rtl/sdram_bus_arbiter_if.sv
// sdram_bus_arbiter_if: requester-side and controller-side signal bundle of sdram_bus_arbiter.
// master is the environment (requesters + controller), slave is the arbiter.
interface sdram_bus_arbiter_if #(
  parameter int NP = 2,
  parameter int AW = 24,
  parameter int DW = 16
);
  logic [NP-1:0]        port_req_read;
  logic [NP-1:0]        port_req_write;
  logic [NP*AW-1:0]     port_req_addr;
  logic [NP-1:0]        port_req_burst;
  logic [NP*3-1:0]      port_req_burst_len;
  logic [NP*DW-1:0]     port_req_wdata;
  logic [NP*DW/8-1:0]   port_req_byteenable;
  logic [NP-1:0]        port_req_ready;
  logic [NP-1:0]        port_rsp_valid;
  logic [DW-1:0]        port_rsp_rdata;
  logic                 ctrl_req_read;
  logic                 ctrl_req_write;
  logic                 ctrl_req_burst;
  logic [AW-1:0]        ctrl_req_addr;
  logic [2:0]           ctrl_req_burst_len;
  logic [DW-1:0]        ctrl_req_wdata;
  logic [DW/8-1:0]      ctrl_req_byteenable;
  logic                 ctrl_req_ready;
  logic                 ctrl_rsp_valid;
  logic [DW-1:0]        ctrl_rsp_rdata;
  logic                 err_orphan_rsp;
  modport master (
    output port_req_read, port_req_write, port_req_addr, port_req_burst, port_req_burst_len,
           port_req_wdata, port_req_byteenable, ctrl_req_ready, ctrl_rsp_valid, ctrl_rsp_rdata,
    input  port_req_ready, port_rsp_valid, port_rsp_rdata, ctrl_req_read, ctrl_req_write,
           ctrl_req_burst, ctrl_req_addr, ctrl_req_burst_len, ctrl_req_wdata,
           ctrl_req_byteenable, err_orphan_rsp
  );
  modport slave (
    input  port_req_read, port_req_write, port_req_addr, port_req_burst, port_req_burst_len,
           port_req_wdata, port_req_byteenable, ctrl_req_ready, ctrl_rsp_valid, ctrl_rsp_rdata,
    output port_req_ready, port_rsp_valid, port_rsp_rdata, ctrl_req_read, ctrl_req_write,
           ctrl_req_burst, ctrl_req_addr, ctrl_req_burst_len, ctrl_req_wdata,
           ctrl_req_byteenable, err_orphan_rsp
  );
endinterface

// File: rtl/sdram_bus_arbiter.sv
// sdram_bus_arbiter: round-robin transaction arbiter sharing one SDRAM controller port,
// with an in-order tag FIFO routing read beats back to the issuing port.
module sdram_bus_arbiter #(
  parameter int NP        = 2,
  parameter int AW        = 24,
  parameter int DW        = 16,
  parameter int TAG_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  sdram_bus_arbiter_if.slave bus
);
  localparam int GW = NP > 1 ? $clog2(NP) : 1;
  localparam int TW = $clog2(TAG_DEPTH);
  localparam int BW = DW / 8;
  typedef enum logic {ARB, XFER} state_t;
  state_t        state_q;
  logic [GW-1:0] grant_q, last_grant_q, pick, head_port;
  logic [2:0]    wbeat_q, rbeat_q, sel_len, head_len;
  logic [TW:0]   wr_ptr_q, rd_ptr_q;
  logic [GW-1:0] tag_port_q [TAG_DEPTH];
  logic [2:0]    tag_len_q [TAG_DEPTH];
  logic          err_q, found, xfer, full, empty, acc_rd, acc_wr, rsp_beat, pop;
  logic          sel_rd, sel_wr, sel_burst, sel_req;
  logic [NP-1:0] req;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [BW-1:0] sel_be;
  always_comb begin
    req = bus.port_req_read | bus.port_req_write;
    pick = last_grant_q;
    found = 1'b0;
    for (int k = 1; k <= NP; k++)
      for (int i = 0; i < NP; i++)
        if (!found && req[i] && (int'(last_grant_q) + k) % NP == i) begin
          pick = GW'(i);
          found = 1'b1;
        end
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    sel_burst = 1'b0;
    sel_len = '0;
    sel_addr = '0;
    sel_wdata = '0;
    sel_be = '0;
    for (int i = 0; i < NP; i++)
      if (grant_q == GW'(i)) begin
        sel_rd = bus.port_req_read[i];
        sel_wr = bus.port_req_write[i];
        sel_burst = bus.port_req_burst[i];
        sel_len = bus.port_req_burst_len[i*3 +: 3];
        sel_addr = bus.port_req_addr[i*AW +: AW];
        sel_wdata = bus.port_req_wdata[i*DW +: DW];
        sel_be = bus.port_req_byteenable[i*BW +: BW];
      end
    sel_req = sel_rd | sel_wr;
    xfer = state_q == XFER;
    bus.ctrl_req_read = xfer & sel_rd;
    bus.ctrl_req_write = xfer & sel_wr & ~sel_rd;
    bus.ctrl_req_burst = xfer & sel_burst;
    bus.ctrl_req_addr = xfer ? sel_addr : '0;
    bus.ctrl_req_burst_len = xfer ? sel_len : '0;
    bus.ctrl_req_wdata = xfer ? sel_wdata : '0;
    bus.ctrl_req_byteenable = xfer ? sel_be : '0;
    acc_rd = bus.ctrl_req_read & bus.ctrl_req_ready;
    acc_wr = bus.ctrl_req_write & bus.ctrl_req_ready;
    bus.port_req_ready = '0;
    for (int i = 0; i < NP; i++)
      bus.port_req_ready[i] = xfer && grant_q == GW'(i) && bus.ctrl_req_ready;
    empty = wr_ptr_q == rd_ptr_q;
    full = wr_ptr_q[TW] != rd_ptr_q[TW] && wr_ptr_q[TW-1:0] == rd_ptr_q[TW-1:0];
    head_port = tag_port_q[rd_ptr_q[TW-1:0]];
    head_len = tag_len_q[rd_ptr_q[TW-1:0]];
    rsp_beat = bus.ctrl_rsp_valid & ~empty;
    pop = rsp_beat && rbeat_q == head_len;
    bus.port_rsp_valid = '0;
    for (int i = 0; i < NP; i++)
      bus.port_rsp_valid[i] = rsp_beat && head_port == GW'(i);
    bus.port_rsp_rdata = bus.ctrl_rsp_rdata;
    bus.err_orphan_rsp = err_q;
  end
  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk)
    if (acc_rd) begin
      tag_port_q[wr_ptr_q[TW-1:0]] <= grant_q;
      tag_len_q[wr_ptr_q[TW-1:0]] <= sel_burst ? sel_len : 3'd0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ARB;
      grant_q <= '0;
      last_grant_q <= GW'(NP - 1);
      wbeat_q <= '0;
      rbeat_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ARB) begin
        if (!full && found) begin
          grant_q <= pick;
          wbeat_q <= '0;
          state_q <= XFER;
        end
      end else if (acc_rd) begin
        last_grant_q <= grant_q;
        state_q <= ARB;
      end else if (acc_wr) begin
        // Write bursts keep the bus locked until the final beat is accepted.
        if (!sel_burst || wbeat_q == sel_len) begin
          last_grant_q <= grant_q;
          state_q <= ARB;
        end else
          wbeat_q <= wbeat_q + 3'd1;
      end else if (!sel_req)
        state_q <= ARB;
      if (acc_rd)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rsp_beat) begin
        rbeat_q <= pop ? 3'd0 : rbeat_q + 3'd1;
        if (pop)
          rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (bus.ctrl_rsp_valid && empty)
        err_q <= 1'b1;
    end
endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// tb_sdram_bus_arbiter: vector table for round-robin reads, hand sequences for bursts,
// tag-FIFO full stall, orphan response and mid-burst reset; response beats via scoreboard.
module tb_sdram_bus_arbiter;
  localparam int NP = 2, AW = 24, DW = 16, TAG_DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sdram_bus_arbiter_if #(.NP(NP), .AW(AW), .DW(DW)) bus ();
  sdram_bus_arbiter #(.NP(NP), .AW(AW), .DW(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  typedef struct packed {logic [NP-1:0] vld; logic [DW-1:0] data;} rsp_t;
  typedef struct packed {
    logic [1:0]    rd;
    logic          rsp;
    logic [1:0]    rdy;
    logic          crd;
    logic [AW-1:0] addr;
    logic [1:0]    rv;
  } vec_t;
  rsp_t sb [$];
  vec_t tbl [10];
  int n_tests = 0;
  int n_fail = 0;
  bit sb_en = 1'b0;
  int cnt;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic push_exp(input logic [NP-1:0] vld, input logic [DW-1:0] data);
    rsp_t e;
    e.vld = vld;
    e.data = data;
    sb.push_back(e);
  endtask
  task automatic mon();
    rsp_t e;
    if (sb_en && bus.port_rsp_valid != '0) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got valid 0x%0h, expected none", bus.port_rsp_valid);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(bus.port_rsp_valid), 32'(e.vld));
        chk("rsp_rdata", 32'(bus.port_rsp_rdata), 32'(e.data));
      end
    end
  endtask
  task automatic settle();
    #1;
    mon();
  endtask
  task automatic adv();
    @(negedge clk);
  endtask
  task automatic cyc();
    settle();
    adv();
  endtask
  task automatic set_port(input int p, input logic rd, input logic wr, input logic bst,
                          input logic [2:0] len, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.port_req_read[p] = rd;
    bus.port_req_write[p] = wr;
    bus.port_req_burst[p] = bst;
    bus.port_req_burst_len[p*3 +: 3] = len;
    bus.port_req_addr[p*AW +: AW] = addr;
    bus.port_req_wdata[p*DW +: DW] = wd;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{2'b11, 1'b0, 2'b00, 1'b0, 24'h000, 2'b00};
    tbl[1] = '{2'b11, 1'b0, 2'b01, 1'b1, 24'h100, 2'b00};
    tbl[2] = '{2'b11, 1'b1, 2'b00, 1'b0, 24'h000, 2'b01};
    tbl[3] = '{2'b11, 1'b0, 2'b10, 1'b1, 24'h200, 2'b00};
    tbl[4] = '{2'b11, 1'b1, 2'b00, 1'b0, 24'h000, 2'b10};
    tbl[5] = '{2'b11, 1'b0, 2'b01, 1'b1, 24'h100, 2'b00};
    tbl[6] = '{2'b11, 1'b1, 2'b00, 1'b0, 24'h000, 2'b01};
    tbl[7] = '{2'b11, 1'b0, 2'b10, 1'b1, 24'h200, 2'b00};
    tbl[8] = '{2'b00, 1'b1, 2'b00, 1'b0, 24'h000, 2'b10};
    tbl[9] = '{2'b00, 1'b0, 2'b00, 1'b0, 24'h000, 2'b00};
    bus.port_req_read = '0;
    bus.port_req_write = '0;
    bus.port_req_burst = '0;
    bus.port_req_burst_len = '0;
    bus.port_req_addr = '0;
    bus.port_req_wdata = '0;
    bus.port_req_byteenable = '1;
    bus.ctrl_req_ready = 1'b1;
    bus.ctrl_rsp_valid = 1'b1;
    bus.ctrl_rsp_rdata = '0;
    set_port(0, 1'b1, 1'b0, 1'b0, 3'd0, 24'h100, 16'h0);
    set_port(1, 1'b1, 1'b0, 1'b0, 3'd0, 24'h200, 16'h0);
    repeat (2) adv();
    settle();
    chk("rst_ready", 32'(bus.port_req_ready), 0);
    chk("rst_ctrl_read", 32'(bus.ctrl_req_read), 0);
    chk("rst_rsp_valid", 32'(bus.port_rsp_valid), 0);
    chk("rst_err", 32'(bus.err_orphan_rsp), 0);
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.port_req_read = tbl[i].rd;
      bus.ctrl_rsp_valid = tbl[i].rsp;
      bus.ctrl_rsp_rdata = tbl[i].rsp ? 16'hA000 + 16'(i) : 16'h0;
      settle();
      chk($sformatf("rr%0d_ready", i), 32'(bus.port_req_ready), 32'(tbl[i].rdy));
      chk($sformatf("rr%0d_ctrl_read", i), 32'(bus.ctrl_req_read), 32'(tbl[i].crd));
      chk($sformatf("rr%0d_addr", i), 32'(bus.ctrl_req_addr), 32'(tbl[i].addr));
      chk($sformatf("rr%0d_rsp_valid", i), 32'(bus.port_rsp_valid), 32'(tbl[i].rv));
      adv();
    end
    bus.ctrl_rsp_valid = 1'b0;
    sb_en = 1'b1;
    set_port(0, 1'b0, 1'b1, 1'b1, 3'd3, 24'h300, 16'hD000);
    set_port(1, 1'b1, 1'b0, 1'b0, 3'd0, 24'h400, 16'h0);
    settle();
    chk("wb_bubble0", 32'(bus.port_req_ready), 0);
    adv();
    for (int k = 0; k < 4; k++) begin
      bus.port_req_wdata[DW-1:0] = 16'hD000 + 16'(k);
      settle();
      chk($sformatf("wb_beat%0d_ready", k), 32'(bus.port_req_ready), 32'h1);
      chk($sformatf("wb_beat%0d_write", k), 32'(bus.ctrl_req_write), 1);
      chk($sformatf("wb_beat%0d_wdata", k), 32'(bus.ctrl_req_wdata), 32'h0000D000 + k);
      adv();
    end
    bus.port_req_write[0] = 1'b0;
    settle();
    chk("wb_bubble1", 32'(bus.port_req_ready), 0);
    adv();
    settle();
    chk("wb_p1_ready", 32'(bus.port_req_ready), 32'h2);
    chk("wb_p1_read", 32'(bus.ctrl_req_read), 1);
    chk("wb_p1_addr", 32'(bus.ctrl_req_addr), 32'h400);
    adv();
    bus.port_req_read[1] = 1'b0;
    bus.ctrl_rsp_valid = 1'b1;
    bus.ctrl_rsp_rdata = 16'hBEEF;
    push_exp(2'b10, 16'hBEEF);
    cyc();
    bus.ctrl_rsp_valid = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 3'd0, 24'h500, 16'h0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      settle();
      cnt += int'(bus.port_req_ready[0]);
      adv();
    end
    chk("full_grant_count", 32'(cnt), 4);
    bus.ctrl_rsp_valid = 1'b1;
    bus.ctrl_rsp_rdata = 16'h1111;
    push_exp(2'b01, 16'h1111);
    settle();
    chk("full_stall_ready", 32'(bus.port_req_ready), 0);
    adv();
    bus.ctrl_rsp_valid = 1'b0;
    settle();
    chk("full_rearb_ready", 32'(bus.port_req_ready), 0);
    adv();
    settle();
    chk("full_fifth_grant", 32'(bus.port_req_ready), 32'h1);
    adv();
    bus.port_req_read[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.ctrl_rsp_valid = 1'b1;
      bus.ctrl_rsp_rdata = 16'h2000 + 16'(k);
      push_exp(2'b01, 16'h2000 + 16'(k));
      cyc();
    end
    bus.ctrl_rsp_valid = 1'b0;
    set_port(1, 1'b1, 1'b0, 1'b1, 3'd7, 24'h600, 16'h0);
    set_port(0, 1'b1, 1'b0, 1'b0, 3'd0, 24'h700, 16'h0);
    settle();
    chk("br_bubble", 32'(bus.port_req_ready), 0);
    adv();
    settle();
    chk("br_p1_ready", 32'(bus.port_req_ready), 32'h2);
    chk("br_p1_burst", 32'(bus.ctrl_req_burst), 1);
    chk("br_p1_len", 32'(bus.ctrl_req_burst_len), 7);
    adv();
    bus.port_req_read[1] = 1'b0;
    cyc();
    settle();
    chk("br_p0_ready", 32'(bus.port_req_ready), 32'h1);
    chk("br_p0_burst", 32'(bus.ctrl_req_burst), 0);
    adv();
    bus.port_req_read[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      bus.ctrl_rsp_valid = k != 4;
      bus.ctrl_rsp_rdata = 16'h7000 + 16'(cnt);
      if (k != 4) begin
        push_exp(cnt < 8 ? 2'b10 : 2'b01, 16'h7000 + 16'(cnt));
        cnt++;
      end
      cyc();
    end
    bus.ctrl_rsp_valid = 1'b0;
    cyc();
    chk("orph_err_before", 32'(bus.err_orphan_rsp), 0);
    bus.ctrl_rsp_valid = 1'b1;
    bus.ctrl_rsp_rdata = 16'h5555;
    settle();
    chk("orph_rsp_valid", 32'(bus.port_rsp_valid), 0);
    adv();
    bus.ctrl_rsp_valid = 1'b0;
    settle();
    chk("orph_err_set", 32'(bus.err_orphan_rsp), 1);
    adv();
    repeat (3) cyc();
    settle();
    chk("orph_err_sticky", 32'(bus.err_orphan_rsp), 1);
    adv();
    set_port(0, 1'b0, 1'b1, 1'b1, 3'd3, 24'h800, 16'hE000);
    settle();
    chk("rb_bubble", 32'(bus.port_req_ready), 0);
    adv();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("rb_beat%0d_ready", k), 32'(bus.port_req_ready), 32'h1);
      adv();
    end
    rst_n = 1'b0;
    bus.ctrl_rsp_rdata = '0;
    settle();
    chk("rb_ready", 32'(bus.port_req_ready), 0);
    chk("rb_write", 32'(bus.ctrl_req_write), 0);
    chk("rb_addr", 32'(bus.ctrl_req_addr), 0);
    chk("rb_wdata", 32'(bus.ctrl_req_wdata), 0);
    chk("rb_len", 32'(bus.ctrl_req_burst_len), 0);
    chk("rb_err", 32'(bus.err_orphan_rsp), 0);
    adv();
    set_port(0, 1'b0, 1'b1, 1'b0, 3'd0, 24'h900, 16'h1234);
    set_port(1, 1'b1, 1'b0, 1'b0, 3'd0, 24'hA00, 16'h0);
    rst_n = 1'b1;
    settle();
    chk("rr_after_rst_bubble", 32'(bus.port_req_ready), 0);
    adv();
    settle();
    chk("rr_after_rst_grant", 32'(bus.port_req_ready), 32'h1);
    chk("rr_after_rst_write", 32'(bus.ctrl_req_write), 1);
    adv();
    bus.port_req_read = '0;
    bus.port_req_write = '0;
    repeat (2) cyc();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
